sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter_pkg.sv | 13 +
 rtl/sram_like_arbiter_id_fifo.sv | 56 +++++
 rtl/sram_like_arbiter.sv | 112 +++++++++++
 tb/tb_sram_like_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg -- shared sram-like field widths and arbitration mode constants
// Revision: 1.0
`default_nettype none
package sram_like_arbiter_pkg;
  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam int MODE_RR    = 1;
  localparam int MODE_FIXED = 0;
endpackage
`default_nettype wire

// File: rtl/sram_like_arbiter_id_fifo.sv
// id_fifo -- order FIFO of granted channel ids, popped as responses return in order
// Revision: 1.0
`default_nettype none
module id_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [W-1:0]             push_id,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int unsigned FULL_I = DEPTH;
  localparam logic [PW:0] FULL_CNT = FULL_I[PW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap on natural overflow
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter -- NCH sram-like masters onto one slave, responses routed back in acceptance order
// Revision: 1.0
`default_nettype none
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 4,
  parameter int RR    = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NCH-1:0]           m_req,
  input  logic [NCH-1:0]           m_wr,
  input  logic [SIZE_W*NCH-1:0]    m_size,
  input  logic [STRB_W*NCH-1:0]    m_wstrb,
  input  logic [ADDR_W*NCH-1:0]    m_addr,
  input  logic [DATA_W*NCH-1:0]    m_wdata,
  output logic [NCH-1:0]           m_addr_ok,
  output logic [NCH-1:0]           m_data_ok,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [SIZE_W-1:0]        s_size,
  output logic [STRB_W-1:0]        s_wstrb,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  input  logic [DATA_W-1:0]        s_rdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err
);
  localparam int IW = $clog2(NCH);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_id;
  logic          locked;
  logic [IW-1:0] arb_id;
  logic [IW-1:0] grant;
  logic [IW-1:0] head;
  logic          full;
  logic          empty;
  logic          accept;
  logic          pop_ok;

  always_comb begin
    logic        found;
    int unsigned idx;
    found  = 1'b0;
    idx    = 0;
    arb_id = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (RR == MODE_RR) ? (int'(rr_ptr) + k) % NCH : k;
      if (!found && m_req[idx]) begin
        arb_id = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  // a presented but unaccepted request keeps the bus until the slave takes it
  assign grant = locked ? lock_id : arb_id;

  assign s_req   = resetn && m_req[grant] && !full;
  assign s_wr    = m_wr[grant];
  assign s_size  = m_size[SIZE_W*int'(grant) +: SIZE_W];
  assign s_wstrb = m_wstrb[STRB_W*int'(grant) +: STRB_W];
  assign s_addr  = m_addr[ADDR_W*int'(grant) +: ADDR_W];
  assign s_wdata = m_wdata[DATA_W*int'(grant) +: DATA_W];

  assign accept  = s_req && s_addr_ok;
  assign pop_ok  = resetn && s_data_ok && !empty;
  assign m_rdata = s_rdata;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign m_addr_ok[i] = accept && (grant == IW'(i));
    assign m_data_ok[i] = pop_ok && (head == IW'(i));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr  <= '0;
      locked  <= 1'b0;
      lock_id <= '0;
      err     <= 1'b0;
    end else begin
      locked <= s_req && !s_addr_ok;
      if (s_req && !s_addr_ok) lock_id <= grant;
      if (accept && (RR == MODE_RR)) begin
        rr_ptr <= (grant == IW'(NCH - 1)) ? '0 : grant + 1'b1;
      end
      if (s_data_ok && empty) err <= 1'b1;
    end
  end

  id_fifo #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (grant),
    .pop     (s_data_ok),
    .head    (head),
    .count   (outstanding),
    .full    (full),
    .empty   (empty)
  );
endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter -- directed scenarios plus randomized traffic against a queue-based reference model
// Revision: 1.0
`default_nettype none
module tb_sram_like_arbiter;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int RR    = 1;

  logic               clk = 1'b0;
  logic               resetn;
  logic [NCH-1:0]     m_req, m_wr;
  logic [2*NCH-1:0]   m_size;
  logic [4*NCH-1:0]   m_wstrb;
  logic [32*NCH-1:0]  m_addr, m_wdata;
  logic [NCH-1:0]     m_addr_ok, m_data_ok;
  logic [31:0]        m_rdata;
  logic               s_req, s_wr;
  logic [1:0]         s_size;
  logic [3:0]         s_wstrb;
  logic [31:0]        s_addr, s_wdata;
  logic               s_addr_ok, s_data_ok;
  logic [31:0]        s_rdata;
  logic [$clog2(DEPTH):0] outstanding;
  logic               err;

  always #5 clk = ~clk;

  sram_like_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .RR(RR)) dut (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of channel ids in acceptance order
  int             q[$];
  int             mdl_ptr = 0;
  int             mdl_lock_ch = 0;
  bit             mdl_lock = 1'b0;
  bit             mdl_err = 1'b0;
  bit             mdl_valid = 1'b0;
  logic [NCH-1:0] mdl_last_aok = '0;

  always @(negedge clk) begin : compare
    int             g;
    int             c;
    bit             sreq;
    bit             popv;
    logic [NCH-1:0] eaok;
    logic [NCH-1:0] edok;
    if (!resetn) begin
      chk("rst_s_req", s_req, 0);
      chk("rst_m_addr_ok", m_addr_ok, 0);
      chk("rst_m_data_ok", m_data_ok, 0);
      q.delete();
      mdl_ptr = 0; mdl_lock = 0; mdl_lock_ch = 0; mdl_err = 0;
      mdl_last_aok = '0;
      mdl_valid = 1'b1;
    end else if (mdl_valid) begin
      g = -1;
      if (mdl_lock) g = mdl_lock_ch;
      else begin
        for (int k = 0; k < NCH; k++) begin
          c = RR ? (mdl_ptr + k) % NCH : k;
          if (g < 0 && m_req[c]) g = c;
        end
      end
      sreq = 1'b0;
      if (g >= 0) sreq = m_req[g] && (q.size() < DEPTH);
      eaok = (sreq && s_addr_ok) ? (NCH'(1) << g) : '0;
      popv = s_data_ok && (q.size() > 0);
      edok = popv ? (NCH'(1) << q[0]) : '0;

      chk("s_req", s_req, sreq);
      if (sreq) begin
        chk("s_addr", s_addr, m_addr[g*32 +: 32]);
        chk("s_wdata", s_wdata, m_wdata[g*32 +: 32]);
        chk("s_wr", s_wr, m_wr[g]);
        chk("s_size", s_size, m_size[g*2 +: 2]);
        chk("s_wstrb", s_wstrb, m_wstrb[g*4 +: 4]);
      end
      chk("m_addr_ok", m_addr_ok, eaok);
      chk("m_data_ok", m_data_ok, edok);
      chk("m_rdata", m_rdata, s_rdata);
      chk("outstanding", outstanding, q.size());
      chk("err", err, mdl_err);

      if (s_data_ok && q.size() == 0) mdl_err = 1'b1;
      if (popv) void'(q.pop_front());
      if (sreq && s_addr_ok) begin
        q.push_back(g);
        if (RR) mdl_ptr = (g + 1) % NCH;
      end
      mdl_lock = sreq && !s_addr_ok;
      if (mdl_lock) mdl_lock_ch = g;
      mdl_last_aok = eaok;
    end
  end

  task automatic mid(); @(negedge clk); #1; endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  task automatic set_ch(input int i, input logic [31:0] addr);
    m_addr[i*32 +: 32]  = addr;
    m_wdata[i*32 +: 32] = $urandom;
    m_wr[i]             = $urandom_range(0, 1);
    m_size[i*2 +: 2]    = 2'd2;
    m_wstrb[i*4 +: 4]   = 4'hf;
  endtask

  initial begin
    resetn = 0; m_req = '0; m_wr = '0; m_size = '0; m_wstrb = '0;
    m_addr = '0; m_wdata = '0; s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    mid();
    chk("lit_rst_outstanding", outstanding, 0);
    chk("lit_rst_err", err, 0);
    chk("lit_rst_s_req", s_req, 0);
    nxt();

    // alternating round-robin grants with one-cycle responses
    set_ch(0, 32'h100); set_ch(1, 32'h200);
    m_req = 2'b11; s_addr_ok = 1;
    mid(); chk("lit_rr_aok0", m_addr_ok, 2'b01); chk("lit_rr_addr0", s_addr, 32'h100);
    nxt(); set_ch(0, 32'h104); s_data_ok = 1; s_rdata = 32'hd0;
    mid(); chk("lit_rr_aok1", m_addr_ok, 2'b10); chk("lit_rr_dok0", m_data_ok, 2'b01);
    chk("lit_rr_rdata", m_rdata, 32'hd0);
    nxt(); set_ch(1, 32'h204);
    mid(); chk("lit_rr_aok2", m_addr_ok, 2'b01); chk("lit_rr_dok1", m_data_ok, 2'b10);
    nxt(); set_ch(0, 32'h108);
    mid(); chk("lit_rr_aok3", m_addr_ok, 2'b10); chk("lit_rr_dok2", m_data_ok, 2'b01);
    chk("lit_rr_outstanding", outstanding, 1);
    nxt(); m_req = 2'b00;
    mid(); chk("lit_rr_dok3", m_data_ok, 2'b10);
    nxt(); s_data_ok = 0;

    // grant lock while the slave stalls
    set_ch(1, 32'h300); m_req = 2'b10; s_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("lit_lock_addr", s_addr, 32'h300); chk("lit_lock_aok", m_addr_ok, 2'b00);
      nxt();
    end
    set_ch(0, 32'h400); m_req = 2'b11;
    mid(); chk("lit_lock_hold", s_addr, 32'h300);
    nxt(); s_addr_ok = 1;
    mid(); chk("lit_lock_acc1", m_addr_ok, 2'b10);
    nxt(); m_req = 2'b01;
    mid(); chk("lit_lock_acc0", m_addr_ok, 2'b01);
    nxt(); m_req = 2'b00; s_data_ok = 1;
    mid(); chk("lit_lock_dok1", m_data_ok, 2'b10);
    nxt();
    mid(); chk("lit_lock_dok0", m_data_ok, 2'b01);
    nxt(); s_data_ok = 0;

    // fill to DEPTH, then a pop without same-cycle bypass
    m_req = 2'b01;
    for (int i = 0; i < 4; i++) begin set_ch(0, 32'h500 + 4*i); nxt(); end
    set_ch(0, 32'h600); s_data_ok = 1;
    mid(); chk("lit_full_outstanding", outstanding, 4); chk("lit_full_s_req", s_req, 0);
    chk("lit_full_aok", m_addr_ok, 2'b00); chk("lit_full_dok", m_data_ok, 2'b01);
    nxt(); s_data_ok = 0;
    mid(); chk("lit_full_out3", outstanding, 3); chk("lit_full_reassert", s_req, 1);
    nxt();

    // drain to 2, then push+pop across pointer wrap
    m_req = 2'b00; s_data_ok = 1;
    nxt(); nxt();
    set_ch(1, 32'h700); m_req = 2'b10;
    mid(); chk("lit_pp_out", outstanding, 2); chk("lit_pp_aok", m_addr_ok, 2'b10);
    chk("lit_pp_dok", m_data_ok, 2'b01);
    nxt(); m_req = 2'b00;
    mid(); chk("lit_pp_out_kept", outstanding, 2); chk("lit_pp_dok_a", m_data_ok, 2'b01);
    nxt();
    mid(); chk("lit_pp_dok_wrap", m_data_ok, 2'b10);
    nxt();

    // data_ok while empty
    mid(); chk("lit_empty_dok", m_data_ok, 2'b00);
    nxt(); s_data_ok = 0;
    repeat (3) begin mid(); chk("lit_err_sticky", err, 1); nxt(); end

    // reset with transactions in flight
    m_req = 2'b01;
    repeat (3) begin set_ch(0, $urandom); nxt(); end
    resetn = 0; s_data_ok = 1;
    mid(); chk("lit_rst_force_sreq", s_req, 0); chk("lit_rst_force_aok", m_addr_ok, 0);
    chk("lit_rst_force_dok", m_data_ok, 0);
    nxt(); resetn = 1; m_req = 2'b00; s_data_ok = 0;
    mid(); chk("lit_rst_flush", outstanding, 0); chk("lit_rst_err_clr", err, 0);
    nxt();

    // randomized traffic; masters hold an unaccepted request
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!(m_req[i] && !mdl_last_aok[i])) begin
          m_req[i] = ($urandom_range(0, 9) < 6);
          set_ch(i, $urandom);
          m_size[i*2 +: 2]  = 2'($urandom_range(0, 3));
          m_wstrb[i*4 +: 4] = 4'($urandom_range(0, 15));
        end
      end
      s_addr_ok = ($urandom_range(0, 9) < 7);
      s_data_ok = ((q.size() > 0) && ($urandom_range(0, 9) < 5)) || ($urandom_range(0, 199) == 0);
      s_rdata   = $urandom;
      resetn    = ($urandom_range(0, 299) != 0);
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
